// File: rtl/mmio_timer_responder.sv
// rtl/mmio_timer_responder.sv - memory-mapped prescaled 32-bit timer responder on CPU data port 2
module mmio_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memory_address2,
    input  logic [31:0] memory_wdata2,
    input  logic        memory_write_enable2,
    output logic [31:0] memory_rdata2,
    output logic        hit,
    output logic        irq
);

    localparam logic [PRESC_W-1:0] PCNT_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic               ctrl_en;
    logic               ctrl_auto_reload;
    logic               ctrl_irq_en;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] pcnt;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic               match;

    logic [2:0]  offset;
    logic        wr;
    logic        wr_ctrl, wr_presc, wr_count, wr_compare, wr_status;
    logic        tick;
    logic [31:0] count_nxt;
    logic        cmp_hit;
    logic        match_set;

    assign hit    = (memory_address2[31:5] == BASE_ADDR[31:5]) && (memory_address2[1:0] == 2'b00);
    assign offset = memory_address2[4:2];
    assign wr     = hit && memory_write_enable2;

    assign wr_ctrl    = wr && (offset == 3'd0);
    assign wr_presc   = wr && (offset == 3'd1);
    assign wr_count   = wr && (offset == 3'd2);
    assign wr_compare = wr && (offset == 3'd3);
    assign wr_status  = wr && (offset == 3'd4);

    assign tick      = ctrl_en && (pcnt == prescale);
    assign count_nxt = count + 32'd1;
    assign cmp_hit   = (count_nxt == compare);
    // A CPU write to COUNT suppresses both the increment and the match check
    assign match_set = tick && !wr_count && cmp_hit;

    assign irq = match && ctrl_irq_en;

    always_comb begin
        memory_rdata2 = 32'd0;
        if (hit) begin
            case (offset)
                3'd0: memory_rdata2[2:0] = {ctrl_irq_en, ctrl_auto_reload, ctrl_en};
                3'd1: memory_rdata2[PRESC_W-1:0] = prescale;
                3'd2: memory_rdata2 = count;
                3'd3: memory_rdata2 = compare;
                3'd4: memory_rdata2[0] = match;
                default: memory_rdata2 = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en          <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            prescale         <= '0;
            pcnt             <= '0;
            count            <= 32'd0;
            compare          <= 32'hFFFF_FFFF;
            match            <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en          <= memory_wdata2[0];
                ctrl_auto_reload <= memory_wdata2[1];
                ctrl_irq_en      <= memory_wdata2[2];
            end
            if (wr_presc) begin
                prescale <= memory_wdata2[PRESC_W-1:0];
            end
            if (wr_compare) begin
                compare <= memory_wdata2;
            end

            if (wr_ctrl || wr_presc || !ctrl_en || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PCNT_ONE;
            end

            if (wr_count) begin
                count <= memory_wdata2;
            end else if (tick) begin
                count <= (cmp_hit && ctrl_auto_reload) ? 32'd0 : count_nxt;
            end

            // Set has priority over write-one-to-clear
            match <= match_set || (match && !(wr_status && memory_wdata2[0]));
        end
    end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// tb/tb_mmio_timer_responder.sv - scoreboard bench for mmio_timer_responder
module tb_mmio_timer_responder;

    logic        clk;
    logic        reset;
    logic [31:0] memory_address2;
    logic [31:0] memory_wdata2;
    logic        memory_write_enable2;
    logic [31:0] memory_rdata2;
    logic        hit;
    logic        irq;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] A_CTRL   = 32'h400;
    localparam logic [31:0] A_PRESC  = 32'h404;
    localparam logic [31:0] A_COUNT  = 32'h408;
    localparam logic [31:0] A_CMP    = 32'h40C;
    localparam logic [31:0] A_STATUS = 32'h410;

    mmio_timer_responder dut (
        .clk                  (clk),
        .reset                (reset),
        .memory_address2      (memory_address2),
        .memory_wdata2        (memory_wdata2),
        .memory_write_enable2 (memory_write_enable2),
        .memory_rdata2        (memory_rdata2),
        .hit                  (hit),
        .irq                  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        memory_address2      = addr;
        memory_wdata2        = data;
        memory_write_enable2 = 1'b1;
        @(posedge clk);
        #1;
        memory_write_enable2 = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic h);
        memory_write_enable2 = 1'b0;
        memory_address2      = addr;
        #1;
        data = memory_rdata2;
        h    = hit;
    endtask

    task automatic test_reset;
        logic [31:0] d, e;
        logic        h;
        logic [31:0] rst_vals [8];
        rst_vals = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        #2;
        total++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else passed++;
        #20 reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) exp_q.push_back(rst_vals[i]);
        for (int i = 0; i < 8; i++) begin
            bus_read(32'h400 + 32'(i * 4), d, h);
            e = exp_q.pop_front();
            total++;
            if (d !== e || h !== 1'b1) $display("FAIL reset_read[%0d]: got %h hit %b expected %h hit 1", i, d, h, e);
            else passed++;
        end
        exp_q.push_back(32'h0);
        bus_read(32'h401, d, h);
        e = exp_q.pop_front();
        total++;
        if (d !== e || h !== 1'b0) $display("FAIL misaligned_read: got %h hit %b expected %h hit 0", d, h, e); else passed++;
        bus_read(32'h420, d, h);
        total++;
        if (h !== 1'b0) $display("FAIL out_of_window_hit: got %b expected 0", h); else passed++;
        bus_write(32'h401, 32'h7);
        bus_write(32'h414, 32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        bus_read(A_CTRL, d, h);
        e = exp_q.pop_front();
        total++;
        if (d !== e) $display("FAIL misaligned_write_ignored: got %h expected %h", d, e); else passed++;
        bus_read(32'h414, d, h);
        e = exp_q.pop_front();
        total++;
        if (d !== e) $display("FAIL reserved_write_ignored: got %h expected %h", d, e); else passed++;
    endtask

    task automatic test_free_run;
        logic [31:0] d, e;
        logic        h;
        bus_write(A_PRESC, 32'd3);
        bus_write(A_CMP, 32'd5);
        bus_write(A_CTRL, 32'd1);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            exp_q.push_back(32'(k / 4));
            exp_q.push_back((k >= 20) ? 32'd1 : 32'd0);
            bus_read(A_COUNT, d, h);
            e = exp_q.pop_front();
            total++;
            if (d !== e) $display("FAIL free_run_count k=%0d: got %h expected %h", k, d, e); else passed++;
            bus_read(A_STATUS, d, h);
            e = exp_q.pop_front();
            total++;
            if (d !== e) $display("FAIL free_run_match k=%0d: got %h expected %h", k, d, e); else passed++;
            total++;
            if (irq !== 1'b0) $display("FAIL free_run_irq k=%0d: got %b expected 0", k, irq); else passed++;
        end
    endtask

    task automatic test_auto_reload;
        logic [31:0] d, e;
        logic        h;
        bus_write(A_CTRL, 32'd0);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_STATUS, 32'd1);
        bus_write(A_PRESC, 32'd0);
        bus_write(A_CMP, 32'd3);
        bus_write(A_CTRL, 32'd7);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp_q.push_back(32'(k % 3));
            bus_read(A_COUNT, d, h);
            e = exp_q.pop_front();
            total++;
            if (d !== e) $display("FAIL reload_count k=%0d: got %h expected %h", k, d, e); else passed++;
            total++;
            if (irq !== (k >= 3)) $display("FAIL reload_irq k=%0d: got %b expected %b", k, irq, (k >= 3)); else passed++;
        end
        bus_write(A_STATUS, 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) begin
                @(posedge clk); #1;
            end
            exp_q.push_back(32'(k + 1) % 32'd3);
            bus_read(A_COUNT, d, h);
            e = exp_q.pop_front();
            total++;
            if (d !== e) $display("FAIL w1c_count k=%0d: got %h expected %h", k, d, e); else passed++;
            total++;
            if (irq !== (k == 2)) $display("FAIL w1c_irq k=%0d: got %b expected %b", k, irq, (k == 2)); else passed++;
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d, e;
        logic        h;
        bus_write(A_CTRL, 32'd0);
        bus_write(A_COUNT, 32'hFFFF_FFFE);
        bus_write(A_CMP, 32'd10);
        bus_write(A_STATUS, 32'd1);
        bus_write(A_PRESC, 32'd0);
        bus_write(A_CTRL, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            exp_q.push_back(32'hFFFF_FFFE + 32'(k));
            exp_q.push_back((k >= 12) ? 32'd1 : 32'd0);
            bus_read(A_COUNT, d, h);
            e = exp_q.pop_front();
            total++;
            if (d !== e) $display("FAIL wrap_count k=%0d: got %h expected %h", k, d, e); else passed++;
            bus_read(A_STATUS, d, h);
            e = exp_q.pop_front();
            total++;
            if (d !== e) $display("FAIL wrap_match k=%0d: got %h expected %h", k, d, e); else passed++;
        end
    endtask

    task automatic test_collisions;
        logic [31:0] d, e;
        logic        h;
        logic [31:0] exp_status [4];
        logic [31:0] exp_count  [4];
        exp_status = '{32'd1, 32'd1, 32'd0, 32'd0};
        exp_count  = '{32'd3, 32'd4, 32'd5, 32'd100};
        bus_write(A_CTRL, 32'd0);
        bus_write(A_STATUS, 32'd1);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CMP, 32'd3);
        bus_write(A_PRESC, 32'd0);
        bus_write(A_CTRL, 32'd1);
        repeat (2) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(exp_status[k]);
            exp_q.push_back(exp_count[k]);
            case (k)
                0: bus_write(A_STATUS, 32'd1);
                1: bus_write(A_STATUS, 32'd0);
                2: bus_write(A_STATUS, 32'd1);
                default: bus_write(A_COUNT, 32'd100);
            endcase
            bus_read(A_STATUS, d, h);
            e = exp_q.pop_front();
            total++;
            if (d !== e) $display("FAIL collide_status k=%0d: got %h expected %h", k, d, e); else passed++;
            bus_read(A_COUNT, d, h);
            e = exp_q.pop_front();
            total++;
            if (d !== e) $display("FAIL collide_count k=%0d: got %h expected %h", k, d, e); else passed++;
        end
        @(posedge clk); #1;
        exp_q.push_back(32'd101);
        bus_read(A_COUNT, d, h);
        e = exp_q.pop_front();
        total++;
        if (d !== e) $display("FAIL count_after_write: got %h expected %h", d, e); else passed++;
        exp_q.push_back(32'd0);
        bus_write(A_CMP, 32'd102);
        bus_read(A_STATUS, d, h);
        e = exp_q.pop_front();
        total++;
        if (d !== e) $display("FAIL compare_write_old_value: got %h expected %h", d, e); else passed++;
    endtask

    task automatic test_async_reset;
        logic [31:0] d, e;
        logic        h;
        bus_write(A_CTRL, 32'd0);
        bus_write(A_STATUS, 32'd1);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CMP, 32'd2);
        bus_write(A_PRESC, 32'd0);
        bus_write(A_CTRL, 32'd5);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b expected 1", irq); else passed++;
        #1 reset = 1'b0;
        #1;
        total++;
        if (irq !== 1'b0) $display("FAIL async_reset_irq: got %b expected 0", irq); else passed++;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'hFFFF_FFFF);
        bus_read(A_COUNT, d, h);
        e = exp_q.pop_front();
        total++;
        if (d !== e) $display("FAIL async_reset_count: got %h expected %h", d, e); else passed++;
        bus_read(A_CMP, d, h);
        e = exp_q.pop_front();
        total++;
        if (d !== e) $display("FAIL async_reset_compare: got %h expected %h", d, e); else passed++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back(32'd0);
        bus_read(A_COUNT, d, h);
        e = exp_q.pop_front();
        total++;
        if (d !== e) $display("FAIL post_reset_idle_count: got %h expected %h", d, e); else passed++;
        bus_write(A_CTRL, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(32'd2);
        bus_read(A_COUNT, d, h);
        e = exp_q.pop_front();
        total++;
        if (d !== e) $display("FAIL post_reset_resume_count: got %h expected %h", d, e); else passed++;
    endtask

    initial begin
        reset                = 1'b0;
        memory_address2      = 32'd0;
        memory_wdata2        = 32'd0;
        memory_write_enable2 = 1'b0;
        test_reset();
        test_free_run();
        test_auto_reload();
        test_wrap();
        test_collisions();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
